// File: rtl/data_memory_ctrl.sv
// Word-addressed data memory controller with byte-enable writes, a fixed
// number of wait states per access, a Ready/Done handshake and out-of-range
// detection. Lets the CPU memory stage stall on slow memory through the
// handshake instead of through a change in pipeline timing.
module data_memory_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic                    Clock,
    input  logic                    Reset_n,
    input  logic [31:0]             Address,
    input  logic [DATA_WIDTH-1:0]   WriteData,
    input  logic [DATA_WIDTH/8-1:0] ByteEnable,
    input  logic                    MemRead,
    input  logic                    MemWrite,
    output logic                    Ready,
    output logic                    Done,
    output logic [DATA_WIDTH-1:0]   ReadData,
    output logic                    AddrError
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state_reg;
    logic [3:0]      count_reg;
    logic [31:0]     addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [LANES-1:0]      be_reg;
    logic            write_reg;

    // RAM contents survive reset.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             access;

    // The full 32-bit compare keeps high address bits from aliasing into the RAM.
    assign in_range = (addr_reg < 32'(DEPTH));
    assign idx      = addr_reg[IDX_W-1:0];
    // The access happens on the edge that leaves WAIT with the counter exhausted.
    assign access   = (state_reg == S_WAIT) && (count_reg == 4'd0);

    // Control FSM: accept and latch a request, count down wait states, then
    // pulse Done for one cycle. All handshake outputs are registered.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= S_IDLE;
            count_reg <= 4'd0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            be_reg    <= '0;
            write_reg <= 1'b0;
            Ready     <= 1'b1;
            Done      <= 1'b0;
            AddrError <= 1'b0;
            ReadData  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    Done      <= 1'b0;
                    AddrError <= 1'b0;
                    if (MemRead || MemWrite) begin
                        addr_reg  <= Address;
                        wdata_reg <= WriteData;
                        be_reg    <= ByteEnable;
                        // A write wins when both requests are raised together.
                        write_reg <= MemWrite;
                        count_reg <= 4'(WAIT_STATES);
                        state_reg <= S_WAIT;
                        Ready     <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (count_reg != 4'd0) begin
                        count_reg <= count_reg - 4'd1;
                    end else begin
                        state_reg <= S_RESP;
                        Done      <= 1'b1;
                        AddrError <= !in_range;
                        if (!write_reg) begin
                            ReadData <= in_range ? mem[idx] : '0;
                        end
                    end
                end
                S_RESP: begin
                    Done      <= 1'b0;
                    AddrError <= 1'b0;
                    Ready     <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: begin
                    Done      <= 1'b0;
                    AddrError <= 1'b0;
                    Ready     <= 1'b1;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // RAM write port: only the enabled byte lanes of an in-range write change.
    always_ff @(posedge Clock) begin
        if (access && write_reg && in_range) begin
            for (int b = 0; b < LANES; b++) begin
                if (be_reg[b]) begin
                    mem[idx][8*b +: 8] <= wdata_reg[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: a vector table for single accesses on a
// two-wait-state instance, plus hand sequences for request toggling during
// WAIT, reset mid-write, and back-to-back reads on a zero-wait-state instance.
module tb_data_memory_ctrl;

    logic        Clock;
    logic        Reset_n;
    logic [31:0] Address, WriteData;
    logic [3:0]  ByteEnable;
    logic        MemRead, MemWrite;
    logic        Ready, Done, AddrError;
    logic [31:0] ReadData;

    logic [31:0] addr0, wdata0;
    logic [3:0]  be0;
    logic        read0, write0;
    logic        ready0, done0, err0;
    logic [31:0] rdata0;

    int n_vec = 0;
    int n_err = 0;

    data_memory_ctrl #(.DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(2)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Address(Address), .WriteData(WriteData),
        .ByteEnable(ByteEnable), .MemRead(MemRead), .MemWrite(MemWrite),
        .Ready(Ready), .Done(Done), .ReadData(ReadData), .AddrError(AddrError)
    );

    data_memory_ctrl #(.DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(0)) dut0 (
        .Clock(Clock), .Reset_n(Reset_n), .Address(addr0), .WriteData(wdata0),
        .ByteEnable(be0), .MemRead(read0), .MemWrite(write0),
        .Ready(ready0), .Done(done0), .ReadData(rdata0), .AddrError(err0)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        chk_rd;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One complete access on the WAIT_STATES=2 instance; returns the number of
    // edges from accept to the edge after which Done is seen (-1 on timeout).
    task automatic do_access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] b, output int lat, output logic err);
        @(negedge Clock);
        MemWrite = wr; MemRead = !wr; Address = a; WriteData = d; ByteEnable = b;
        @(posedge Clock); #1;
        MemWrite = 1'b0; MemRead = 1'b0;
        chk("ready_low_after_accept", 32'(Ready), 32'd0);
        lat = -1;
        err = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (lat < 0) begin
                @(posedge Clock); #1;
                if (Done) begin
                    lat = k;
                    err = AddrError;
                end else begin
                    chk("no_err_without_done", 32'(AddrError), 32'd0);
                end
            end
        end
        if (lat >= 0) begin
            @(posedge Clock); #1;
            chk("ready_back_after_resp", 32'(Ready), 32'd1);
            chk("done_single_cycle", 32'(Done), 32'd0);
        end
    endtask

    int          lat;
    logic        err;
    int          done_cnt;
    logic [8:0]  done_pat, ready_pat;

    initial begin
        vecs[0]  = '{1'b1, 32'd5,          32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'd5,          32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'd5,          32'h000000AA, 4'h1, 1'b0, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'd5,          32'h0,        4'h0, 1'b1, 32'hDEADBEAA, 1'b0};
        vecs[4]  = '{1'b0, 32'd1024,       32'h0,        4'h0, 1'b1, 32'h0,        1'b1};
        vecs[5]  = '{1'b1, 32'd0,          32'h12345678, 4'hF, 1'b0, 32'h0,        1'b0};
        vecs[6]  = '{1'b1, 32'd1024,       32'h00000001, 4'hF, 1'b0, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 32'd0,          32'h0,        4'h0, 1'b1, 32'h12345678, 1'b0};
        vecs[8]  = '{1'b1, 32'd5,          32'hFFFFFFFF, 4'h0, 1'b0, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 32'd5,          32'h0,        4'h0, 1'b1, 32'hDEADBEAA, 1'b0};
        vecs[10] = '{1'b1, 32'd5,          32'h11223344, 4'hA, 1'b0, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 32'd5,          32'h0,        4'h0, 1'b1, 32'h11AD33AA, 1'b0};
        vecs[12] = '{1'b1, 32'h10000000,   32'hFFFFFFFF, 4'hF, 1'b0, 32'h0,        1'b1};
        vecs[13] = '{1'b0, 32'h10000005,   32'h0,        4'h0, 1'b1, 32'h0,        1'b1};

        Reset_n = 1'b0;
        Address = '0; WriteData = '0; ByteEnable = '0; MemRead = 1'b0; MemWrite = 1'b0;
        addr0 = '0; wdata0 = '0; be0 = '0; read0 = 1'b0; write0 = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        chk("reset_ready", 32'(Ready), 32'd1);
        chk("reset_done", 32'(Done), 32'd0);
        chk("reset_rdata", ReadData, 32'd0);
        chk("reset_err", 32'(AddrError), 32'd0);
        @(negedge Clock);
        Reset_n = 1'b1;

        // Table of single accesses
        for (int i = 0; i < 14; i++) begin
            do_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, lat, err);
            $display("vec %0d: %s addr=0x%08h be=%h latency=%0d rdata=0x%08h err=%0b",
                     i, vecs[i].wr ? "WR" : "RD", vecs[i].addr, vecs[i].be, lat, ReadData, err);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
            chk($sformatf("vec%0d_addr_error", i), 32'(err), 32'(vecs[i].exp_err));
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), ReadData, vecs[i].exp_rdata);
        end

        // Requests toggled during WAIT are ignored; data from the latched address
        @(negedge Clock);
        MemRead = 1'b1; Address = 32'd0;
        @(posedge Clock); #1;
        Address = 32'd5; MemRead = 1'b0; MemWrite = 1'b0;
        @(posedge Clock); #1;
        MemRead = 1'b1; Address = 32'd1024;
        @(posedge Clock); #1;
        MemRead = 1'b0; Address = 32'd5;
        done_cnt = (Done) ? 1 : 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge Clock); #1;
            if (Done) begin
                done_cnt++;
                chk("toggle_rdata", ReadData, 32'h12345678);
                chk("toggle_err", 32'(AddrError), 32'd0);
            end
        end
        $display("toggle: done pulses=%0d rdata=0x%08h", done_cnt, ReadData);
        chk("toggle_done_count", 32'(done_cnt), 32'd1);

        // Reset during WAIT drops the pending write
        do_access(1'b1, 32'd7, 32'hA5A5A5A5, 4'hF, lat, err);
        chk("pre_write7_latency", 32'(lat), 32'd3);
        @(negedge Clock);
        MemWrite = 1'b1; Address = 32'd7; WriteData = 32'h00000055; ByteEnable = 4'hF;
        @(posedge Clock); #1;
        MemWrite = 1'b0;
        @(posedge Clock); #1;
        Reset_n = 1'b0;
        #1;
        chk("midwait_reset_ready", 32'(Ready), 32'd1);
        chk("midwait_reset_done", 32'(Done), 32'd0);
        chk("midwait_reset_rdata", ReadData, 32'd0);
        @(negedge Clock);
        @(negedge Clock);
        Reset_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge Clock); #1;
            if (Done) done_cnt++;
        end
        chk("aborted_write_no_done", 32'(done_cnt), 32'd0);
        do_access(1'b0, 32'd7, 32'h0, 4'h0, lat, err);
        $display("reset-abort: read addr 7 -> 0x%08h latency=%0d", ReadData, lat);
        chk("aborted_write_latency", 32'(lat), 32'd3);
        chk("aborted_write_rdata", ReadData, 32'hA5A5A5A5);

        // Zero wait states: simultaneous read+write, then MemRead held high
        @(negedge Clock);
        write0 = 1'b1; read0 = 1'b1; addr0 = 32'd3; wdata0 = 32'hCAFEF00D; be0 = 4'hF;
        @(posedge Clock); #1;
        write0 = 1'b0;
        done_pat = '0;
        ready_pat = '0;
        for (int k = 0; k < 9; k++) begin
            @(posedge Clock); #1;
            done_pat[k]  = done0;
            ready_pat[k] = ready0;
        end
        read0 = 1'b0;
        $display("ws0: done pattern=%b ready pattern=%b rdata=0x%08h", done_pat, ready_pat, rdata0);
        chk("ws0_done_pattern", 32'(done_pat), 32'(9'b001001001));
        chk("ws0_ready_pattern", 32'(ready_pat), 32'(9'b010010010));
        chk("ws0_write_wins_rdata", rdata0, 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
